// File: rtl/mcu_pkg.sv
// mcu_pkg: opcodes, instruction field positions, sequencer states and error codes
package mcu_pkg;
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_LOAD  = 4'd7;
    localparam logic [3:0] OP_STORE = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 28;
    localparam int ADDR_HI = 27;
    localparam int ADDR_LO = 20;
    localparam int IMM_HI  = 19;
    localparam int IMM_LO  = 0;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_EXEC    = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_STORE || op == OP_HALT;
    endfunction
endpackage

// File: rtl/mcu_prog_ram.sv
// mcu_prog_ram: program buffer with one write port and a registered read port
module mcu_prog_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/mcu_issue_ctrl.sv
// mcu_issue_ctrl: fetches, decodes and issues buffered instructions to the execution unit
module mcu_issue_ctrl
    import mcu_pkg::*;
#(
    parameter int OP_SZ      = 32,
    parameter int ADDR_W     = 8,
    parameter int PROG_DEPTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] ld_addr,
    input  logic [31:0]                   ld_data,
    input  logic                          start,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [3:0]                    iss_op_code,
    output logic [ADDR_W-1:0]             iss_addr,
    output logic [OP_SZ-1:0]              iss_imm,
    input  logic                          rsp_valid,
    input  logic                          rsp_err,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic [$clog2(PROG_DEPTH)-1:0] pc
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    state_t        state, state_n;
    logic [31:0]   ins;
    logic [3:0]    op;
    logic [CW-1:0] cnt;
    logic          last, expired;

    mcu_prog_ram #(.DEPTH(PROG_DEPTH), .W(32)) u_ram (
        .clk   (clk),
        .we    (ld_en && state == S_IDLE),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pc),
        .rdata (ins)
    );

    assign op        = ins[OPC_HI:OPC_LO];
    assign last      = pc == AW'(PROG_DEPTH - 1);
    assign expired   = cnt == CW'(TIMEOUT - 1);
    assign iss_valid = state == S_ISSUE;
    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = start ? S_FETCH : S_IDLE;
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: state_n = op == OP_HALT ? S_DONE : op_legal(op) ? S_ISSUE : S_ERR;
            S_ISSUE:  state_n = iss_ready ? S_WAIT : S_ISSUE;
            // a response on the expiry cycle still counts as a response
            S_WAIT:   state_n = rsp_valid ? (rsp_err ? S_ERR : last ? S_DONE : S_FETCH)
                                          : expired ? S_ERR : S_WAIT;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= '0;
            cnt         <= '0;
            iss_op_code <= '0;
            iss_addr    <= '0;
            iss_imm     <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pc       <= '0;
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                end
                S_DECODE: if (op_legal(op) && op != OP_HALT) begin
                    iss_op_code <= op;
                    iss_addr    <= ADDR_W'(ins[ADDR_HI:ADDR_LO]);
                    iss_imm     <= OP_SZ'(ins[IMM_HI:IMM_LO]);
                end else if (!op_legal(op)) begin
                    err      <= 1'b1;
                    err_code <= ERR_ILLEGAL;
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: if (rsp_valid) begin
                    if (rsp_err) begin
                        err      <= 1'b1;
                        err_code <= ERR_EXEC;
                    end else if (!last) pc <= pc + 1'b1;
                end else if (expired) begin
                    err      <= 1'b1;
                    err_code <= ERR_TIMEOUT;
                end else cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mcu_issue_ctrl.sv
// tb_mcu_issue_ctrl: directed vectors with hand-computed expectations for mcu_issue_ctrl
module tb_mcu_issue_ctrl;
    logic        clk = 0, reset = 0, ld_en = 0, start = 0;
    logic        iss_ready = 0, rsp_valid = 0, rsp_err = 0;
    logic [3:0]  ld_addr = 0;
    logic [31:0] ld_data = 0;
    logic        iss_valid, busy, done, err;
    logic [3:0]  iss_op_code, pc;
    logic [7:0]  iss_addr;
    logic [31:0] iss_imm;
    logic [1:0]  err_code;
    int n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    mcu_issue_ctrl dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op_code(iss_op_code), .iss_addr(iss_addr), .iss_imm(iss_imm),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .pc(pc)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [7:0] a, input logic [19:0] imm);
        return {op, a, imm};
    endfunction

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 0;
    endtask

    task automatic go();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic respond(input logic e);
        rsp_valid = 1; rsp_err = e;
        tick();
        rsp_valid = 0; rsp_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("reset_ctl", {iss_valid, busy, done, err, err_code, pc}, 0);
        check("reset_fields", {iss_op_code, iss_addr, iss_imm}, 0);
        reset = 1;
        tick();

        // two instructions then HALT, responses two cycles after each issue
        load(0, ins(4'h0, 8'h01, 20'h5));
        load(1, ins(4'h6, 8'h02, 20'h3));
        load(2, ins(4'hF, 8'h00, 20'h0));
        iss_ready = 1;
        go();
        check("t1_busy", busy, 1);
        tick();
        check("t1_decode_novalid", iss_valid, 0);
        tick();
        check("t1_issue0", {iss_valid, iss_op_code, iss_addr, iss_imm}, {1'b1, 4'h0, 8'h01, 32'h5});
        tick();
        check("t1_xfer0", iss_valid, 0);
        tick();
        respond(0);
        check("t1_pc1", pc, 1);
        tick(2);
        check("t1_issue1", {iss_valid, iss_op_code, iss_addr, iss_imm}, {1'b1, 4'h6, 8'h02, 32'h3});
        tick(2);
        respond(0);
        check("t1_pc2", pc, 2);
        tick(2);
        check("t1_done", {done, err, pc}, {1'b1, 1'b0, 4'd2});
        tick();
        check("t1_idle", {done, busy}, 0);

        // ready held low for 10 cycles during ISSUE
        load(0, ins(4'h7, 8'h33, 20'hABCDE));
        load(1, ins(4'hF, 8'h00, 20'h0));
        iss_ready = 0;
        go();
        tick(2);
        for (int i = 0; i < 10; i++) begin
            check("t2_stall", {iss_valid, iss_op_code, iss_addr, iss_imm}, {1'b1, 4'h7, 8'h33, 32'h000ABCDE});
            tick();
        end
        iss_ready = 1; rsp_valid = 1;
        tick();
        iss_ready = 0; rsp_valid = 0;
        check("t2_xfer", iss_valid, 0);
        tick();
        check("t2_sameresp_ignored", {busy, pc}, {1'b1, 4'd0});
        respond(0);
        check("t2_pc1", pc, 1);
        tick(2);
        check("t2_done", done, 1);
        tick();

        // illegal opcode at pc 0
        load(0, ins(4'hC, 8'h00, 20'h0));
        iss_ready = 1;
        go();
        check("t3_fetch_novalid", iss_valid, 0);
        tick();
        check("t3_decode_novalid", iss_valid, 0);
        tick();
        check("t3_err", {iss_valid, err, err_code}, {1'b0, 1'b1, 2'd1});
        tick();
        check("t3_idle", {busy, err, err_code}, {1'b0, 1'b1, 2'd1});

        // timeout with no response, then restart and answer on the last cycle
        load(0, ins(4'h0, 8'h00, 20'h1));
        load(1, ins(4'hF, 8'h00, 20'h0));
        go();
        tick(3);
        tick(63);
        check("t4_pre_timeout", {busy, err, err_code}, {1'b1, 1'b0, 2'd0});
        tick();
        check("t4_timeout", {err, err_code}, {1'b1, 2'd2});
        tick();
        check("t4_idle", {busy, err}, {1'b0, 1'b1});
        go();
        check("t4_restart_clears", {err, err_code}, 0);
        tick(3);
        tick(63);
        respond(0);
        check("t4_rsp_wins", {err, err_code, busy, pc}, {1'b0, 2'd0, 1'b1, 4'd1});
        tick(2);
        check("t4_done", done, 1);
        tick();

        // execution error on the second instruction
        load(0, ins(4'h0, 8'h00, 20'h0));
        load(1, ins(4'h1, 8'h00, 20'h0));
        load(2, ins(4'h2, 8'h00, 20'h0));
        load(3, ins(4'hF, 8'h00, 20'h0));
        go();
        tick(3);
        respond(0);
        tick(2);
        check("t5_issue_sub", {iss_valid, iss_op_code}, {1'b1, 4'h1});
        tick();
        respond(1);
        check("t5_exec_err", {err, err_code, pc}, {1'b1, 2'd3, 4'd1});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_issue", {iss_valid, busy}, 0);
        end

        // load/start ignored while busy, reset aborts in WAIT, buffer retained
        load(0, ins(4'h0, 8'h01, 20'h5));
        load(1, ins(4'hF, 8'h00, 20'h0));
        go();
        ld_en = 1; ld_addr = 0; ld_data = ins(4'h2, 8'hEE, 20'h12345); start = 1;
        tick();
        ld_en = 0; start = 0;
        tick();
        check("t6_issue", {iss_op_code, iss_addr, iss_imm}, {4'h0, 8'h01, 32'h5});
        tick(2);
        reset = 0;
        tick();
        check("t6_reset_ctl", {iss_valid, busy, done, err, err_code, pc}, 0);
        check("t6_reset_fields", {iss_op_code, iss_addr, iss_imm}, 0);
        reset = 1;
        go();
        tick(2);
        check("t6_retained", {iss_valid, iss_op_code, iss_addr, iss_imm}, {1'b1, 4'h0, 8'h01, 32'h5});
        tick();
        start = 1;
        tick();
        start = 0;
        check("t6_start_ignored", {busy, iss_valid, pc}, {1'b1, 1'b0, 4'd0});
        respond(0);
        check("t6_pc1", pc, 1);
        tick(2);
        check("t6_done", done, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
